// File: rtl/decode_ctrl_if.sv
// ID-to-EX control bus of the decode stage: instruction in, registered control bundle out.
interface decode_ctrl_if;
    logic [31:0] Instruction_i;
    logic        InstrValid_i;
    logic        Flush_i;
    logic        Valid_o;
    logic [1:0]  ALUOp_o;
    logic        ALU_A_Src_o;
    logic [1:0]  ALU_B_Src_o;
    logic        BrBase_o;
    logic        BrEn_o;
    logic        UncBr_o;
    logic        MemWrEn_o;
    logic        MemRdEn_o;
    logic        WB_Src_o;
    logic        RegWrEn_o;
    logic [4:0]  Rd_o;
    logic        Illegal_o;
    logic        MulDivBusy_o;
    logic        Stall_o;

    modport master (
        output Instruction_i, InstrValid_i, Flush_i,
        input  Valid_o, ALUOp_o, ALU_A_Src_o, ALU_B_Src_o, BrBase_o, BrEn_o, UncBr_o,
               MemWrEn_o, MemRdEn_o, WB_Src_o, RegWrEn_o, Rd_o, Illegal_o,
               MulDivBusy_o, Stall_o
    );

    modport slave (
        input  Instruction_i, InstrValid_i, Flush_i,
        output Valid_o, ALUOp_o, ALU_A_Src_o, ALU_B_Src_o, BrBase_o, BrEn_o, UncBr_o,
               MemWrEn_o, MemRdEn_o, WB_Src_o, RegWrEn_o, Rd_o, Illegal_o,
               MulDivBusy_o, Stall_o
    );
endinterface

// File: rtl/decode_ctrl_stage.sv
// RV32I(M) decode stage: registers the control bundle into ID/EX, inserts load-use
// bubbles and holds the front end while a multi-cycle MUL/DIV occupies EX.
module decode_ctrl_stage #(
    parameter bit          MEXT_EN = 1'b1,
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned DIV_LAT = 33
) (
    input  logic         Clk_i,
    input  logic         Rst_ni,
    decode_ctrl_if.slave bus
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [7:0] MUL_L     = 8'(MUL_LAT);
    localparam logic [7:0] DIV_L     = 8'(DIV_LAT);

    typedef enum logic {IDLE, BUSY} state_t;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       a_src;
        logic [1:0] b_src;
        logic       br_base;
        logic       br_en;
        logic       unc_br;
        logic       mem_wr;
        logic       mem_rd;
        logic       wb_src;
        logic       reg_wr;
    } ctrl_t;

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rs1, rs2, rd;
    ctrl_t       dec;
    logic        dec_illegal, use1, use2, is_m;
    logic [7:0]  lat;

    ctrl_t       ex_q;
    logic        valid_q, illegal_q;
    logic [4:0]  rd_q;
    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        lu, busy, stall, start_m;

    assign instr  = bus.Instruction_i;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign lat    = instr[14] ? DIV_L : MUL_L;

    always_comb begin
        dec         = '0;
        dec_illegal = 1'b0;
        use1        = 1'b0;
        use2        = 1'b0;
        is_m        = 1'b0;
        case (opcode)
            OP_R: begin
                // funct7 0000001 is the M extension; without it that encoding is illegal
                if (instr[31:25] == 7'b0000001) begin
                    if (MEXT_EN) begin
                        dec  = ctrl_t'(12'b11_0_00_0_0_0_0_0_0_1);
                        is_m = 1'b1;
                        use1 = 1'b1;
                        use2 = 1'b1;
                    end else begin
                        dec_illegal = 1'b1;
                    end
                end else begin
                    dec  = ctrl_t'(12'b00_0_00_0_0_0_0_0_0_1);
                    use1 = 1'b1;
                    use2 = 1'b1;
                end
            end
            OP_I:      begin dec = ctrl_t'(12'b00_0_01_0_0_0_0_0_0_1); use1 = 1'b1; end
            OP_LOAD:   begin dec = ctrl_t'(12'b01_0_01_0_0_0_0_1_1_1); use1 = 1'b1; end
            OP_STORE:  begin dec = ctrl_t'(12'b01_0_01_0_0_0_1_0_0_0); use1 = 1'b1; use2 = 1'b1; end
            OP_BRANCH: begin dec = ctrl_t'(12'b00_0_00_0_1_0_0_0_0_0); use1 = 1'b1; use2 = 1'b1; end
            OP_LUI:    dec = ctrl_t'(12'b10_0_01_0_0_0_0_0_0_1);
            OP_JAL:    dec = ctrl_t'(12'b01_1_10_0_0_1_0_0_0_1);
            OP_JALR:   begin dec = ctrl_t'(12'b01_1_10_1_0_1_0_0_0_1); use1 = 1'b1; end
            OP_AUIPC:  dec = ctrl_t'(12'b01_1_01_0_0_0_0_0_0_1);
            default:   dec_illegal = 1'b1;
        endcase
    end

    assign lu = valid_q & ex_q.mem_rd & bus.InstrValid_i & (rd_q != 5'd0) &
                ((use1 & (rs1 == rd_q)) | (use2 & (rs2 == rd_q)));

    assign start_m = bus.InstrValid_i & is_m & ~lu & (lat > 8'd1);

    always_ff @(posedge Clk_i or negedge Rst_ni) begin
        if (!Rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.Flush_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q == BUSY) begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd1) state_d = IDLE;
        end else if (start_m) begin
            state_d = BUSY;
            cnt_d   = lat - 8'd1;
        end
    end

    always_comb begin
        busy  = (state_q == BUSY);
        stall = ~bus.Flush_i & (busy | lu);
    end

    // EX register: flush > hold while BUSY > load-use bubble > decode
    always_ff @(posedge Clk_i or negedge Rst_ni) begin
        if (!Rst_ni) begin
            ex_q      <= '0;
            valid_q   <= 1'b0;
            rd_q      <= '0;
            illegal_q <= 1'b0;
        end else if (bus.Flush_i || (!busy && (lu || !bus.InstrValid_i))) begin
            ex_q      <= '0;
            valid_q   <= 1'b0;
            rd_q      <= '0;
            illegal_q <= 1'b0;
        end else if (!busy) begin
            ex_q      <= dec;
            valid_q   <= 1'b1;
            rd_q      <= rd;
            illegal_q <= dec_illegal;
        end
    end

    assign bus.Valid_o      = valid_q;
    assign bus.ALUOp_o      = ex_q.alu_op;
    assign bus.ALU_A_Src_o  = ex_q.a_src;
    assign bus.ALU_B_Src_o  = ex_q.b_src;
    assign bus.BrBase_o     = ex_q.br_base;
    assign bus.BrEn_o       = ex_q.br_en;
    assign bus.UncBr_o      = ex_q.unc_br;
    assign bus.MemWrEn_o    = ex_q.mem_wr;
    assign bus.MemRdEn_o    = ex_q.mem_rd;
    assign bus.WB_Src_o     = ex_q.wb_src;
    assign bus.RegWrEn_o    = ex_q.reg_wr;
    assign bus.Rd_o         = rd_q;
    assign bus.Illegal_o    = illegal_q;
    assign bus.MulDivBusy_o = busy;
    assign bus.Stall_o      = stall;
endmodule

// File: doc/decode_ctrl_stage.md
# decode_ctrl_stage

Registered, hazard-aware decode control stage for the RV32I(M) pipeline. It decodes the instruction held in ID into the control bundle and registers it into the ID/EX boundary. It detects load-use hazards and holds the front end while a multi-cycle MUL/DIV occupies EX. It sits between the IF/ID register and the execute stage, and takes redirect flushes from branch resolution.

## Interface
- `MEXT_EN`, default 1: 1 decodes M-extension (opcode 0110011, funct7 0000001); 0 treats it as illegal.
- `MUL_LAT`, default 2: EX occupancy in cycles for MUL* (funct3[2]=0), range 1..255.
- `DIV_LAT`, default 33: EX occupancy in cycles for DIV/REM* (funct3[2]=1), range 1..255.
- `Clk_i` in 1: single clock, rising edge.
- `Rst_ni` in 1: asynchronous, active-low reset.
- `Instruction_i` in 32: instruction in ID.
- `InstrValid_i` in 1: ID holds a real instruction.
- `Flush_i` in 1: redirect; kill the ID instruction.
- `Valid_o` out 1: EX slot holds a real instruction.
- `ALUOp_o` out 2: 00 R/I/branch, 01 add, 10 LUI pass, 11 mul/div.
- `ALU_A_Src_o` out 1, `ALU_B_Src_o` out 2, `BrBase_o` out 1, `BrEn_o` out 1, `UncBr_o` out 1, `MemWrEn_o` out 1, `MemRdEn_o` out 1, `WB_Src_o` out 1, `RegWrEn_o` out 1: registered control bundle.
- `Rd_o` out 5: registered destination register, `Instruction_i[11:7]`.
- `Illegal_o` out 1: registered; a valid ID instruction had an unknown opcode.
- `MulDivBusy_o` out 1: a multi-cycle op is occupying EX.
- `Stall_o` out 1: combinational; hold PC and IF/ID this cycle.

## Operation
Bundle order per opcode is {ALUOp, A, B, BrBase, BrEn, UncBr, MemWr, MemRd, WBSrc, RegWr}:
- R 0110011: 00,0,00,0,0,0,0,0,0,1
- I-ALU 0010011: 00,0,01,0,0,0,0,0,0,1
- Load 0000011: 01,0,01,0,0,0,0,1,1,1
- Store 0100011: 01,0,01,0,0,0,1,0,0,0
- Branch 1100011: 00,0,00,0,1,0,0,0,0,0
- LUI 0110111: 10,0,01,0,0,0,0,0,0,1
- JAL 1101111: 01,1,10,0,0,1,0,0,0,1
- JALR 1100111: 01,1,10,1,0,1,0,0,0,1
- AUIPC 0010111: 01,1,01,0,0,0,0,0,0,1
- M-ext (MEXT_EN=1): 11,0,00,0,0,0,0,0,0,1
- Any other opcode: all zero, and `Illegal_o`=1.

A bubble is all bundle bits 0, with `Valid_o`=0, `Rd_o`=0 and `Illegal_o`=0.

Operand use:
- rs1 is used by R, M, I-ALU, Load, Store, Branch and JALR.
- rs2 is used by R, M, Store and Branch.

Load-use hazard (LU) is true when all of the following hold:
- `Valid_o`, `MemRdEn_o` and `InstrValid_i` are all 1.
- `Rd_o`≠0.
- `Rd_o` matches a used rs.

FSM states are IDLE and BUSY, with an 8-bit down-counter `cnt`:
- IDLE to BUSY: an M-ext op is loaded into EX and its latency L>1. `cnt` is set to L-1.
- BUSY: the EX register holds its contents and `cnt` decrements each cycle. Return to IDLE on the edge where `cnt`=1.
- L=1: stay in IDLE; no stall.

EX-register update priority per edge:
1. `Flush_i`: load a bubble. Force IDLE and set `cnt`=0, aborting any BUSY.
2. BUSY: hold.
3. LU: load a bubble.
4. Otherwise: load the decode of `Instruction_i`. If `InstrValid_i`=0, load a bubble.

Output rules:
- `Stall_o` = !`Flush_i` & (BUSY | LU).
- `MulDivBusy_o` = (state==BUSY).

## Timing
- Reset: all outputs 0, state IDLE, `cnt`=0. `Stall_o`=0 while reset is asserted.
- Decode latency is 1 cycle: the ID instruction at edge N appears on outputs after edge N.
- LU inserts exactly one bubble. The stalled instruction issues on the following edge, since the EX load is then a bubble.
- Total EX occupancy of an M op is L cycles, with `Stall_o` high for the last L-1 of them. The younger ID instruction issues on the edge that ends BUSY.
- Flush and LU in the same cycle: the flush wins and `Stall_o`=0.
- Flush while BUSY: the next cycle shows IDLE and a bubble.
- An M op arriving with LU against a preceding load: the bubble comes first, then the M op enters EX and BUSY starts.
- Reset asserted mid-BUSY: immediate return to IDLE and reset outputs.
- Deasserting `InstrValid_i` in IDLE only produces bubbles. No state change.

## Test plan
- Reset, then drive `addi x1,x0,5` (0x00500093) valid. After one edge: `RegWrEn_o`=1, `ALU_B_Src_o`=01, `Rd_o`=1, `Valid_o`=1, `Stall_o`=0.
- Drive `lw x5,0(x2)` then `add x6,x5,x3`. Expected: `Stall_o`=1 for exactly one cycle, one bubble in EX, then the add issues with `ALUOp_o`=00.
- `div x7,x8,x9` with DIV_LAT=33. Expected: `MulDivBusy_o` high 32 cycles, `Stall_o` high 32 cycles, `ALUOp_o`=11 held throughout, next instruction issues on cycle 34.
- Assert `Flush_i` at cycle 10 of a DIV. Expected next cycle: bubble, `MulDivBusy_o`=0, `Stall_o`=0.
- Opcode 0x0000007F valid. Expected: `Illegal_o`=1, `RegWrEn_o`=0. With MEXT_EN=0, `mul` also sets `Illegal_o`=1.
- Drop `Rst_ni` asynchronously mid-BUSY. Expected: all outputs 0 before the next clock edge.
